// File: rtl/exc_commit_ctrl_pkg.sv
// Shared ExcCode constants, FSM encoding and priority encoder for exc_commit_ctrl.
package exc_commit_ctrl_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned IRQ_W  = 6;
    localparam int unsigned CODE_W = 5;

    localparam logic [CODE_W-1:0] EXC_INT  = 5'h00;
    localparam logic [CODE_W-1:0] EXC_ADEL = 5'h04;
    localparam logic [CODE_W-1:0] EXC_ADES = 5'h05;
    localparam logic [CODE_W-1:0] EXC_SYS  = 5'h08;
    localparam logic [CODE_W-1:0] EXC_BP   = 5'h09;
    localparam logic [CODE_W-1:0] EXC_RI   = 5'h0a;
    localparam logic [CODE_W-1:0] EXC_OV   = 5'h0c;

    localparam logic [XLEN-1:0] EXC_VECTOR_DEF  = 32'hbfc00380;
    localparam int unsigned     SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [XLEN-1:0]   badvaddr;
        logic              badv_we;
    } exc_sel_t;

    // Flags are {adel_if, ri, ov, sys, bp, mem_fault}; interrupt outranks all flags.
    function automatic exc_sel_t prioritise(
        input logic              int_pend,
        input logic [IRQ_W-1:0]  flags,
        input logic              is_store,
        input logic [XLEN-1:0]   pc,
        input logic [XLEN-1:0]   badv
    );
        exc_sel_t s;
        s = '0;
        if (int_pend) begin
            s.code = EXC_INT;
        end else if (flags[5]) begin
            s.code     = EXC_ADEL;
            s.badvaddr = pc;
            s.badv_we  = 1'b1;
        end else if (flags[4]) begin
            s.code = EXC_RI;
        end else if (flags[3]) begin
            s.code = EXC_OV;
        end else if (flags[2]) begin
            s.code = EXC_SYS;
        end else if (flags[1]) begin
            s.code = EXC_BP;
        end else if (flags[0]) begin
            s.code     = is_store ? EXC_ADES : EXC_ADEL;
            s.badvaddr = badv;
            s.badv_we  = 1'b1;
        end
        return s;
    endfunction

endpackage

// File: rtl/exc_commit_ctrl_int_sync.sv
// Multi-stage level synchroniser for the hardware interrupt lines (sync active-low reset).
module exc_commit_ctrl_int_sync #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned WIDTH  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
        end
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/exc_commit_ctrl.sv
// Exception/interrupt commit sequencer: WB priority encode, CP0 commit pulse, flush, redirect.
// Optional TIMER_INT_EN folds timer_int into hw_ip[5].
module exc_commit_ctrl
    import exc_commit_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic        wb_bd,
    input  logic [5:0]  wb_exc_flags,
    input  logic        wb_is_store,
    input  logic [31:0] wb_badvaddr,
    input  logic        wb_eret,
    input  logic [5:0]  ext_int,
    input  logic        timer_int,
    input  logic        cp0_ie,
    input  logic        cp0_exl,
    input  logic [7:0]  cp0_im,
    input  logic [1:0]  cp0_ip_sw,
    input  logic [31:0] cp0_epc,
    input  logic        redirect_ready,
    output logic        exc_commit,
    output logic        eret_commit,
    output logic [4:0]  exc_code,
    output logic [31:0] exc_epc,
    output logic        exc_bd,
    output logic [31:0] exc_badvaddr,
    output logic        exc_badv_we,
    output logic [5:0]  hw_ip,
    output logic        flush,
    output logic        stall_wb,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    state_t          state, state_next;
    logic [XLEN-1:0] redirect_pc_next;
    logic [IRQ_W-1:0] hw_sync;
    logic            int_pend;
    logic            take;
    logic            eret_take;
    exc_sel_t        sel;

    exc_commit_ctrl_int_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (IRQ_W)
    ) u_int_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ext_int),
        .dout  (hw_sync)
    );

`ifdef TIMER_INT_EN
    assign hw_ip = {hw_sync[5] | timer_int, hw_sync[4:0]};
`else
    logic unused_timer_int;
    assign unused_timer_int = timer_int;
    assign hw_ip = hw_sync;
`endif

    assign int_pend  = (|({hw_ip, cp0_ip_sw} & cp0_im)) & cp0_ie & ~cp0_exl;
    assign take      = wb_valid & (int_pend | (|wb_exc_flags));
    assign eret_take = wb_valid & wb_eret & ~take;
    assign sel       = prioritise(int_pend, wb_exc_flags, wb_is_store, wb_pc, wb_badvaddr);

    // Commit payload is only meaningful (and only non-zero) during the commit pulse.
    assign exc_code     = exc_commit ? sel.code : '0;
    assign exc_epc      = exc_commit ? (wb_bd ? wb_pc - 32'd4 : wb_pc) : '0;
    assign exc_bd       = exc_commit & wb_bd;
    assign exc_badvaddr = exc_commit ? sel.badvaddr : '0;
    assign exc_badv_we  = exc_commit & sel.badv_we;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            stall_wb       <= 1'b0;
            redirect_valid <= 1'b0;
        end else begin
            state          <= state_next;
            redirect_pc    <= redirect_pc_next;
            flush          <= (state_next == ST_FLUSH);
            stall_wb       <= (state_next != ST_IDLE);
            redirect_valid <= (state_next == ST_REDIRECT);
        end
    end

    // WB is only looked at in IDLE; reset suppresses the combinational pulses.
    always_comb begin
        state_next       = state;
        redirect_pc_next = redirect_pc;
        exc_commit       = 1'b0;
        eret_commit      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rst_n && take) begin
                    exc_commit       = 1'b1;
                    redirect_pc_next = EXC_VECTOR;
                    state_next       = ST_FLUSH;
                end else if (rst_n && eret_take) begin
                    eret_commit      = 1'b1;
                    redirect_pc_next = cp0_epc;
                    state_next       = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_next = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                if (redirect_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
